// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: walks one column low per scan tick, debounces
// press and release on the synchronized rows, and reports {row, col} with a one-clk strobe.
module keypad_scanner #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int                TICK_DIV  = CLOCK_FREQUENCY / SCAN_HZ;
  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]        DEB_LIMIT = 4'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] tick_cnt;
  logic             scan_tick;
  logic [3:0]       row_meta;
  logic [3:0]       rs;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [3:0]       deb_cnt;

  logic [1:0]       col_idx_nxt;
  logic [1:0]       row_idx_nxt;
  logic [3:0]       deb_cnt_nxt;
  logic [3:0]       key_code_nxt;
  logic             key_valid_nxt;
  logic             key_pressed_nxt;

  logic             any_low;
  logic [1:0]       low_row;
  logic             sel_low;
  logic [3:0]       deb_inc;
  logic             deb_done;

  // Scan tick is an enable, not a derived clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (scan_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign scan_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // Lowest-indexed low row wins when several rows are pressed in one column.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) begin
        low_row = 2'(i);
      end
    end
  end

  assign any_low  = (rs != 4'hF);
  assign sel_low  = ~rs[row_idx];
  assign deb_inc  = deb_cnt + 4'd1;
  assign deb_done = (deb_inc == DEB_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (scan_tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            next_state = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (sel_low) begin
            if (deb_done) begin
              next_state = HELD;
            end
          end else begin
            next_state = SCAN;
          end
        end
        HELD: begin
          if (!sel_low) begin
            next_state = DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (!sel_low) begin
            if (deb_done) begin
              next_state = SCAN;
            end
          end else begin
            next_state = HELD;
          end
        end
        default: next_state = SCAN;
      endcase
    end
  end

  always_comb begin
    col_idx_nxt     = col_idx;
    row_idx_nxt     = row_idx;
    deb_cnt_nxt     = deb_cnt;
    key_code_nxt    = key_code;
    key_valid_nxt   = 1'b0;
    key_pressed_nxt = key_pressed;
    if (scan_tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            row_idx_nxt = low_row;
            deb_cnt_nxt = 4'd0;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (sel_low) begin
            deb_cnt_nxt = deb_inc;
            if (deb_done) begin
              key_code_nxt    = {row_idx, col_idx};
              key_valid_nxt   = 1'b1;
              key_pressed_nxt = 1'b1;
            end
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        HELD: begin
          if (!sel_low) begin
            deb_cnt_nxt = 4'd0;
          end
        end
        DEB_RELEASE: begin
          if (!sel_low) begin
            deb_cnt_nxt = deb_inc;
            if (deb_done) begin
              key_pressed_nxt = 1'b0;
              col_idx_nxt     = col_idx + 2'd1;
            end
          end
        end
        default: begin
          deb_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // col is registered from the next column index so it moves on the same edge as col_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      deb_cnt     <= 4'd0;
      col         <= 4'b1110;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      col_idx     <= col_idx_nxt;
      row_idx     <= row_idx_nxt;
      deb_cnt     <= deb_cnt_nxt;
      col         <= ~(4'b0001 << col_idx_nxt);
      key_code    <= key_code_nxt;
      key_valid   <= key_valid_nxt;
      key_pressed <= key_pressed_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: emulates a physical 4x4 keypad on col/row and
// compares the DUT every cycle against a tick-level behavioural model of the scanner.
module tb_keypad_scanner;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row = 4'hF;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;

  logic [15:0] keys = 16'h0000;
  int          checks_total = 0;
  int          checks_passed = 0;
  int          valid_count = 0;
  bit          cmp_en = 1'b0;

  // Model state: scan position, locked row (-1 while scanning), debounce runs.
  int          m_cyc = 0;
  logic [3:0]  m_s1 = 4'hF;
  logic [3:0]  m_s2 = 4'hF;
  int          m_col = 0;
  int          m_row = -1;
  int          m_run = 0;
  int          m_high_run = 0;
  bit          m_pressed = 1'b0;
  bit          m_valid = 1'b0;
  logic [3:0]  m_code = 4'h0;

  keypad_scanner #(
    .CLOCK_FREQUENCY(1000),
    .SCAN_HZ(100),
    .DEBOUNCE_TICKS(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_pressed(key_pressed)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int cycles);
    keys = k;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitRelease(input string name);
    for (int i = 0; i < 200 && key_pressed === 1'b1; i++) @(negedge clk);
    checkOutput(name, {3'b0, key_pressed}, 4'b0000);
  endtask

  // Physical keypad: row r pulled low when a held key (r,c) sits on a driven column c.
  initial forever begin
    logic [3:0] nr;
    @(negedge clk);
    nr = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) nr[r] = 1'b0;
    row = nr;
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cyc = 0; m_s1 = 4'hF; m_s2 = 4'hF; m_col = 0; m_row = -1;
      m_run = 0; m_high_run = 0; m_pressed = 0; m_valid = 0; m_code = 4'h0;
    end else begin
      m_valid = 0;
      if (m_cyc == TICK_DIV - 1) begin
        if (m_row < 0) begin
          if (m_s2 != 4'hF) begin
            for (int i = 0; i < 4 && m_row < 0; i++) if (!m_s2[i]) m_row = i;
            m_run = 0;
          end else m_col = (m_col + 1) % 4;
        end else if (!m_pressed) begin
          if (!m_s2[m_row]) begin
            m_run++;
            if (m_run == DEB) begin
              m_pressed = 1; m_valid = 1; m_high_run = 0;
              m_code = {2'(m_row), 2'(m_col)};
            end
          end else begin
            m_row = -1; m_col = (m_col + 1) % 4;
          end
        end else begin
          if (m_s2[m_row]) begin
            m_high_run++;
            if (m_high_run == DEB + 1) begin
              m_pressed = 0; m_row = -1; m_col = (m_col + 1) % 4;
            end
          end else m_high_run = 0;
        end
      end
      m_cyc = (m_cyc + 1) % TICK_DIV;
      m_s2 = m_s1;
      m_s1 = row;
    end
  end

  initial forever begin
    @(negedge clk);
    if (key_valid === 1'b1) valid_count++;
    if (cmp_en && rst_n) begin
      checkOutput("col", col, 4'b1111 ^ (4'b0001 << m_col));
      checkOutput("key_code", key_code, m_code);
      checkOutput("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      checkOutput("key_pressed", {3'b0, key_pressed}, {3'b0, m_pressed});
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int first;
    int ok;

    repeat (3) @(negedge clk);
    checkOutput("reset col", col, 4'b1110);
    checkOutput("reset key_code", key_code, 4'b0000);
    checkOutput("reset key_valid", {3'b0, key_valid}, 4'b0000);
    checkOutput("reset key_pressed", {3'b0, key_pressed}, 4'b0000);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Idle scan: column index after k edges is (k/10)%4.
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 5)  checkOutput("idle col k5", col, 4'b1110);
      if (k == 15) checkOutput("idle col k15", col, 4'b1101);
      if (k == 25) checkOutput("idle col k25", col, 4'b1011);
      if (k == 35) checkOutput("idle col k35", col, 4'b0111);
      if (k == 45) checkOutput("idle col k45", col, 4'b1110);
    end
    checkCount("idle valid pulses", valid_count, 0);

    // Key (2,2).
    start = valid_count;
    applyStimulus(16'h0400, 150);
    checkCount("k22 valid pulses", valid_count - start, 1);
    checkOutput("k22 key_code", key_code, 4'b1010);
    checkOutput("k22 pressed", {3'b0, key_pressed}, 4'b0001);
    checkOutput("k22 col frozen", col, 4'b1011);
    keys = 16'h0000;
    waitRelease("k22 release timeout");
    checkOutput("k22 resume col", col, 4'b0111);
    repeat (60) @(negedge clk);
    checkCount("k22 no repeat", valid_count - start, 1);

    // Bounce on key (0,1): first attempt aborts, second is accepted.
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (col !== 4'b1101) ok = 1;
    end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (col === 4'b1101) ok = 1;
    end
    checkCount("bounce col1 wait", ok, 1);
    start = valid_count;
    applyStimulus(16'h0002, 10);
    applyStimulus(16'h0000, 5);
    checkOutput("bounce col frozen", col, 4'b1101);
    applyStimulus(16'h0000, 10);
    checkOutput("bounce aborted col", col, 4'b1011);
    checkCount("bounce no output", valid_count - start, 0);
    applyStimulus(16'h0002, 150);
    checkCount("bounce valid pulses", valid_count - start, 1);
    checkOutput("bounce key_code", key_code, 4'b0001);
    keys = 16'h0000;
    waitRelease("bounce release timeout");

    // Rows 1 and 3 in column 0, then key (3,3) while held.
    start = valid_count;
    keys = 16'h1010;
    for (int i = 0; i < 200 && key_pressed !== 1'b1; i++) @(negedge clk);
    checkOutput("multi pressed", {3'b0, key_pressed}, 4'b0001);
    checkOutput("multi key_code", key_code, 4'b0100);
    applyStimulus(16'h9010, 100);
    checkCount("multi valid pulses", valid_count - start, 1);
    checkOutput("multi key_code hold", key_code, 4'b0100);
    checkOutput("multi col frozen", col, 4'b1110);
    keys = 16'h0000;
    waitRelease("multi release timeout");

    // Reset two ticks into press debounce of key (1,2).
    keys = 16'h0040;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (m_row >= 0 && !m_pressed && m_run == 2) ok = 1;
    end
    checkCount("deb2 reached", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset col", col, 4'b1110);
    checkOutput("midreset key_code", key_code, 4'b0000);
    checkOutput("midreset key_valid", {3'b0, key_valid}, 4'b0000);
    checkOutput("midreset key_pressed", {3'b0, key_pressed}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (key_valid === 1'b1 && first < 0) begin
        first = k;
        checkOutput("postreset key_code", key_code, 4'b0110);
      end
    end
    checkCount("postreset valid cycle", first, 60);
    keys = 16'h0000;
    waitRelease("postreset release timeout");

    // Randomized key activity, checked every cycle against the model.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] k;
      k = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) k = k | (16'h0001 << $urandom_range(0, 15));
      applyStimulus(k, $urandom_range(5, 120));
      applyStimulus(16'h0000, $urandom_range(1, 60));
    end
    applyStimulus(16'h0000, 100);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scanner for a 4x4 active-low membrane keypad. It is the input-side counterpart of the multiplexed seven-segment display driver. The block drives one keypad column low at a time and samples the four row lines through a synchronizer. Each press and each release must stay stable for a set number of scan ticks. On each debounced press the block reports a key code with a single-cycle valid strobe, which user logic can use to fill the BCD digits shown on the display.

## Interface
- CLOCK_FREQUENCY, default 100000000: system clock frequency in Hz.
- SCAN_HZ, default 1000: scan tick rate in Hz. TICK_DIV = CLOCK_FREQUENCY / SCAN_HZ must be at least 2.
- DEBOUNCE_TICKS, default 4: number of consecutive stable ticks needed to accept a press or a release. Range 1..15.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- row  input  4  keypad row lines, active low (pulled up externally), asynchronous to clk.
- col  output  4  keypad column drive, one-hot active low. Bit i low selects column i.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key.
- key_valid  output  1  one-clk pulse when a debounced press is accepted.
- key_pressed  output  1  level; high from press acceptance until release acceptance.

## Operation
- Tick generator:
  - Free-running counter 0..TICK_DIV-1. scan_tick is a one-clk enable when the count equals TICK_DIV-1.
  - The block generates no derived clock. All logic runs on clk.
- Row synchronizer: two flip-flops on row, resetting to 4'b1111. Every decision below uses the synchronized rows, rs.
- col is always the active-low one-hot decode of col_idx: 0 gives 1110, 1 gives 1101, 2 gives 1011, 3 gives 0111.
- State machine states: SCAN, DEB_PRESS, HELD, DEB_RELEASE. The actions below happen only on a scan_tick, except where noted.
  - SCAN:
    - If rs != 1111, latch row_idx = the lowest index i with rs[i] low, clear deb_cnt, and go to DEB_PRESS. col_idx is not advanced.
    - Otherwise col_idx advances by 1, wrapping 3 to 0.
  - DEB_PRESS (col_idx frozen):
    - If rs[row_idx] is low, deb_cnt increments. When deb_cnt reaches DEBOUNCE_TICKS, load key_code, pulse key_valid, set key_pressed, and go to HELD.
    - If rs[row_idx] is high, go to SCAN and advance col_idx.
  - HELD (col_idx frozen): if rs[row_idx] is high, clear deb_cnt and go to DEB_RELEASE.
  - DEB_RELEASE:
    - If rs[row_idx] is high, deb_cnt increments. When it reaches DEBOUNCE_TICKS, clear key_pressed, go to SCAN, and advance col_idx.
    - If rs[row_idx] is low, go to HELD with no new key_valid.
- Boundary cases:
  - Several rows low in the same column: the lowest row index wins.
  - While the FSM is outside SCAN, keys in other columns are invisible and are never reported. Other rows in the frozen column are ignored.
  - A bounce during press debounce aborts the press with no output.
  - A bounce during release debounce keeps key_pressed high and emits no repeat strobe.
  - There is no auto-repeat.
  - rst_n asserted at any point returns every register to its reset value immediately, including mid-debounce or while a key is held.
- deb_cnt is 4 bits wide and never exceeds DEBOUNCE_TICKS.

## Timing
- Reset values: col=1110, key_code=0000, key_valid=0, key_pressed=0. Internally: state SCAN, col_idx=0, tick counter=0, deb_cnt=0, synchronizer=1111.
- All outputs are registered. col changes on the clk edge that follows a scan_tick.
- Each column is driven for one full tick period before it is sampled, so the column has a full period to settle.
- Sample point: rs is evaluated on the scan_tick cycle. Synchronizer latency is 2 clk.
- Press latency:
  - Press detected at tick T0.
  - key_valid is high during the clk cycle after tick T(DEBOUNCE_TICKS), i.e. DEBOUNCE_TICKS ticks after detection.
  - key_code updates in the same cycle and holds until the next accepted press.
- Release latency: key_pressed falls in the clk cycle after the DEBOUNCE_TICKS-th consecutive high sample following HELD.
- key_valid is exactly one clk wide. There is no handshake, and consumers must capture it on that cycle.

## Test plan
Bench parameters: CLOCK_FREQUENCY=1000, SCAN_HZ=100 (tick every 10 clk), DEBOUNCE_TICKS=3.

- Reset then idle with row=1111. Required: col cycles 1110, 1101, 1011, 0111, 1110, changing every 10 clk. key_valid stays 0 and key_pressed stays 0.
- Hold row[2] low while col=1011 (column 2), stable for 100 clk. Required: exactly one key_valid pulse, key_code=4'b1010, key_pressed=1, col frozen at 1011.
- Release row[2] and hold it high for 100 clk. Required: key_pressed falls 3 ticks after the first high sample, scanning resumes at column 3 (col=0111), and there is no second key_valid.
- Press bounce: row[0] low for 1 tick, high for 1 tick, then low and stable in column 1. Required: the first attempt aborts with no output, then key_valid fires once with key_code=4'b0001.
- rows 1 and 3 low together in column 0, plus a key pressed later in column 3 while column 0 is still held. Required: key_code=4'b0100, and the column 3 key is never reported.
- Assert rst_n low during DEB_PRESS, two ticks into the debounce. Required: col=1110, key_code=0, key_valid=0 and key_pressed=0 immediately. After release of reset, a full 3-tick debounce is needed before any key_valid.
